// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer datapath.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int              SEC_W   = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] sec);
        return (sec > SEC_MAX) ? SEC_MAX : sec;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its host (display mux, buzzer, front panel).
interface countdown_timer_if
    import timer_pkg::*;
#(
    parameter int MIN_W = 7
) ();

    logic             tick;
    logic             load;
    logic [MIN_W-1:0] load_min;
    logic [SEC_W-1:0] load_sec;
    logic             start;
    logic             pause;
    logic [MIN_W-1:0] minute;
    logic [SEC_W-1:0] second;
    logic             running;
    logic             expired;
    logic             alarm;

    modport master (
        output tick, load, load_min, load_sec, start, pause,
        input  minute, second, running, expired, alarm
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, pause,
        output minute, second, running, expired, alarm
    );

endinterface

// File: rtl/sec_down_counter.sv
// 0..59 modulo down-counter with synchronous load and enable; borrow_o is a
// registered flag that is high for the cycle after a 0 -> 59 wrap.
module sec_down_counter
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [SEC_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [SEC_W-1:0] count_o,
    output logic             zero_o,
    output logic             borrow_o
);

    logic [SEC_W-1:0] count_q, count_d;
    logic             borrow_q, borrow_d;

    always_comb begin
        count_d  = count_q;
        borrow_d = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (count_q == '0) begin
                count_d  = SEC_MAX;
                borrow_d = 1'b1;
            end else begin
                count_d = count_q - SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    assign count_o  = count_q;
    assign zero_o   = (count_q == '0);
    assign borrow_o = borrow_q;

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: minute field, expiry FSM and optional latched alarm.
// Define COUNTDOWN_ALARM_EN to build the alarm latch; otherwise alarm is tied low.
//
// state    | meaning
// ST_IDLE  | preset loaded (or reset), waiting for start
// ST_RUN   | decrementing once per tick
// ST_PAUSE | count frozen, start resumes
// ST_DONE  | reached 00:00, holds until load
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_W   = 7,
    parameter int MAX_MIN = 99
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [MIN_W-1:0] minute_q, minute_d;
    logic             expired_q, expired_d;

    logic [MIN_W-1:0] load_min_clamped;
    logic [SEC_W-1:0] sec_count;
    logic             sec_zero;
    logic             sec_en;
    logic             count_zero;
    // Minutes borrow on the same edge as the wrap, so the registered borrow is not needed here.
    logic             sec_borrow_unused;

    assign load_min_clamped = (bus.load_min > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : bus.load_min;
    assign count_zero       = (minute_q == '0) && sec_zero;

    sec_down_counter u_sec (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.load),
        .load_val_i (clamp_sec(bus.load_sec)),
        .en_i       (sec_en),
        .count_o    (sec_count),
        .zero_o     (sec_zero),
        .borrow_o   (sec_borrow_unused)
    );

    always_comb begin
        state_d   = state_q;
        minute_d  = minute_q;
        expired_d = 1'b0;
        sec_en    = 1'b0;
        if (bus.load) begin
            minute_d = load_min_clamped;
            state_d  = ST_IDLE;
        end else if (bus.start) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                if (count_zero) begin
                    state_d   = ST_DONE;
                    expired_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (bus.pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (bus.tick && state_q == ST_RUN) begin
            sec_en = 1'b1;
            if (sec_zero && minute_q != '0) begin
                minute_d = minute_q - MIN_W'(1);
            end
            if (minute_q == '0 && sec_count == SEC_W'(1)) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            minute_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            minute_q  <= minute_d;
            expired_q <= expired_d;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = alarm_q;
        if (bus.load) begin
            alarm_d = 1'b0;
        end else if (expired_d) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign bus.alarm = 1'b0;
`endif

    assign bus.minute  = minute_q;
    assign bus.second  = sec_count;
    assign bus.running = (state_q == ST_RUN);
    assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random run
// against a model that tracks the remaining time as a plain seconds total.
module tb_countdown_timer;

`ifdef COUNTDOWN_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: remaining seconds plus two flags.
    int m_total;
    bit m_counting, m_done, m_alarm, m_exp;

    countdown_timer_if #(.MIN_W(7)) bus ();

    countdown_timer #(.MIN_W(7), .MAX_MIN(99)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_vec();
        return {7'(m_total / 60), 6'(m_total % 60), m_counting, m_exp, m_alarm & ALARM_ON};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {bus.minute, bus.second, bus.running, bus.expired, bus.alarm};
    endfunction

    task automatic model_step(input bit r, ld, st, ps, tk, input int lm, input int ls);
        m_exp = 1'b0;
        if (r) begin
            m_total = 0; m_counting = 0; m_done = 0; m_alarm = 0;
        end else if (ld) begin
            m_total = ((lm > 99) ? 99 : lm) * 60 + ((ls > 59) ? 59 : ls);
            m_counting = 0; m_done = 0; m_alarm = 0;
        end else if (st) begin
            if (!m_counting && !m_done) begin
                if (m_total == 0) begin
                    m_done = 1; m_exp = 1; m_alarm = 1;
                end else begin
                    m_counting = 1;
                end
            end
        end else if (ps) begin
            m_counting = 0;
        end else if (tk && m_counting) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_counting = 0; m_done = 1; m_exp = 1; m_alarm = 1;
            end
        end
    endtask

    task automatic drive(input bit r, ld, st, ps, tk, input int lm = 0, input int ls = 0);
        reset        = r;
        bus.load     = ld;
        bus.start    = st;
        bus.pause    = ps;
        bus.tick     = tk;
        bus.load_min = 7'(lm);
        bus.load_sec = 6'(ls);
        @(posedge clk);
        model_step(r, ld, st, ps, tk, lm, ls);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== 16'h0000) $display("FAIL reset_init got=%h want=%h", obs_vec(), 16'h0000);
        else n_pass++;
        drive(0, 1, 0, 0, 0, 5, 30);
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (bus.running !== 1'b1 || bus.minute !== 7'd5 || bus.second !== 6'd30)
            $display("FAIL reset_prerun got=%0d:%0d run=%b want=5:30 run=1", bus.minute, bus.second, bus.running);
        else n_pass++;
        drive(1, 1, 1, 0, 1, 9, 9);
        n_checks++;
        if (obs_vec() !== 16'h0000) $display("FAIL reset_midrun got=%h want=%h", obs_vec(), 16'h0000);
        else n_pass++;
    endtask

    task automatic test_borrow();
        drive(0, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.minute !== 7'd0 || bus.second !== 6'd59)
            $display("FAIL borrow_first got=%0d:%0d want=0:59", bus.minute, bus.second);
        else n_pass++;
        for (int i = 0; i < 58; i++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL borrow_step%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.expired !== 1'b1 || bus.running !== 1'b0 || bus.second !== 6'd0 || bus.alarm !== ALARM_ON)
            $display("FAIL borrow_expire got=exp%b run%b sec%0d alm%b want=exp1 run0 sec0 alm%b",
                     bus.expired, bus.running, bus.second, bus.alarm, ALARM_ON);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (bus.expired !== 1'b0 || bus.minute !== 7'd0 || bus.second !== 6'd0)
                $display("FAIL done_hold%0d got=exp%b %0d:%0d want=exp0 0:0", i, bus.expired, bus.minute, bus.second);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        drive(0, 1, 0, 0, 0, 0, 3);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (bus.second !== 6'd2 || bus.running !== 1'b0)
                $display("FAIL pause_hold%0d got=sec%0d run%b want=sec2 run0", i, bus.second, bus.running);
            else n_pass++;
        end
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.second !== 6'd1 || bus.running !== 1'b1 || bus.expired !== 1'b0)
            $display("FAIL pause_resume got=sec%0d run%b exp%b want=sec1 run1 exp0", bus.second, bus.running, bus.expired);
        else n_pass++;
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.second !== 6'd0 || bus.expired !== 1'b1)
            $display("FAIL pause_expire got=sec%0d exp%b want=sec0 exp1", bus.second, bus.expired);
        else n_pass++;
    endtask

    task automatic test_clamp();
        drive(0, 1, 0, 0, 0, 120, 63);
        n_checks++;
        if (bus.minute !== 7'd99 || bus.second !== 6'd59)
            $display("FAIL clamp got=%0d:%0d want=99:59", bus.minute, bus.second);
        else n_pass++;
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        n_checks++;
        if (bus.expired !== 1'b1 || bus.running !== 1'b0 || bus.second !== 6'd0 || bus.minute !== 7'd0)
            $display("FAIL zero_start got=exp%b run%b %0d:%0d want=exp1 run0 0:0",
                     bus.expired, bus.running, bus.minute, bus.second);
        else n_pass++;
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (bus.expired !== 1'b0 || bus.running !== 1'b0)
            $display("FAIL done_restart got=exp%b run%b want=exp0 run0", bus.expired, bus.running);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        drive(0, 1, 0, 0, 0, 2, 10);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 1, 3, 25);
        n_checks++;
        if (bus.minute !== 7'd3 || bus.second !== 6'd25 || bus.running !== 1'b0 || bus.expired !== 1'b0)
            $display("FAIL simul_load got=%0d:%0d run%b exp%b want=3:25 run0 exp0",
                     bus.minute, bus.second, bus.running, bus.expired);
        else n_pass++;
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.minute !== 7'd3 || bus.second !== 6'd25)
            $display("FAIL idle_tick got=%0d:%0d want=3:25", bus.minute, bus.second);
        else n_pass++;
    endtask

    task automatic test_alarm();
        drive(0, 1, 0, 0, 0, 0, 2);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        n_checks++;
        if (bus.alarm !== ALARM_ON || bus.expired !== 1'b1)
            $display("FAIL alarm_rise got=alm%b exp%b want=alm%b exp1", bus.alarm, bus.expired, ALARM_ON);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0);
            n_checks++;
            if (bus.alarm !== ALARM_ON) $display("FAIL alarm_hold%0d got=%b want=%b", i, bus.alarm, ALARM_ON);
            else n_pass++;
        end
        drive(0, 0, 1, 0, 0);
        n_checks++;
        if (bus.alarm !== ALARM_ON || bus.expired !== 1'b0)
            $display("FAIL alarm_start got=alm%b exp%b want=alm%b exp0", bus.alarm, bus.expired, ALARM_ON);
        else n_pass++;
        drive(0, 1, 0, 0, 0, 1, 1);
        n_checks++;
        if (bus.alarm !== 1'b0) $display("FAIL alarm_clear got=%b want=0", bus.alarm);
        else n_pass++;
    endtask

    task automatic test_random();
        bit r, ld, st, ps, tk;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 14) == 0);
            ps = ($urandom_range(0, 29) == 0);
            tk = ($urandom_range(0, 1) == 1);
            drive(r, ld, st, ps, tk, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 1),
                  $urandom_range(0, 63));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random_%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 0, 0, 2, 0);
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 125; i++) begin
            drive(0, 0, 0, 0, 1);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL b2b_%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
        bus.load_min = '0; bus.load_sec = '0;
        m_total = 0; m_counting = 0; m_done = 0; m_alarm = 0; m_exp = 0;
        test_reset();
        test_borrow();
        test_pause();
        test_clamp();
        test_simultaneous();
        test_alarm();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting mm:ss timer that is the counterpart of the up-counting seconds/minute chain in the clock design. It loads a preset minute/second value, decrements once per 1 Hz tick, borrows from minutes when seconds wrap 0 → 59, and flags expiry. It sits beside the real-time clock counters in the lab timer datapath and feeds the display mux and the buzzer driver.

## Interface
Parameters:
- MIN_W, 7, minute field width
- MAX_MIN, 99, largest loadable minute value; larger loads clamp to MAX_MIN

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 1 Hz enable strobe
- load  in  1  load preset from load_min/load_sec
- load_min  in  MIN_W  preset minutes
- load_sec  in  6  preset seconds; values > 59 clamp to 59
- start  in  1  begin or resume countdown
- pause  in  1  freeze countdown
- minute  out  MIN_W  current minutes
- second  out  6  current seconds, 0..59
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when the count reaches 00:00
- alarm  out  1  latched expiry indication; see Configuration

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE, minute = 0, second = 0, running = 0, expired = 0, alarm = 0.
- Priority each cycle: reset > load > start > pause > tick.
- load, any state: registers the clamped preset, moves to IDLE, clears alarm. No decrement occurs in that cycle.
- IDLE/PAUSE + start:
  - If the count is non-zero, go to RUN.
  - If the count is 00:00, go to DONE and pulse expired on the next edge.
- RUN + pause: go to PAUSE. The count holds.
- RUN + tick:
  - If second > 0: second − 1.
  - Else if minute > 0: second = 59 and minute − 1 (borrow).
  - Transition 00:01 → 00:00: on the same edge, state goes to DONE and expired = 1 for exactly one cycle.
- DONE: the count holds at 00:00 and tick is ignored. start goes to DONE again with no new expired pulse. Only load leaves DONE.
- start in RUN and pause in IDLE/DONE have no effect.
- tick is ignored outside RUN. A tick in the same cycle as start/pause/load is ignored.

## Timing
- All outputs are registered and update on the rising edge of clk.
- running follows the state register, with no extra latency.
- Decrement latency is one cycle: the tick sampled at edge N is visible on minute/second after edge N.
- expired is high for one clk cycle, aligned with the edge where the count becomes 00:00 or where start is taken at 00:00.
- Back-to-back ticks in consecutive cycles each decrement. There is no minimum tick spacing.
- Reset asserted mid-count forces the reset values on the next edge, regardless of other inputs.

## Configuration
- COUNTDOWN_ALARM_EN defined:
  - alarm is set on the same edge as expired.
  - alarm stays high in DONE until load or reset.
- COUNTDOWN_ALARM_EN undefined:
  - alarm is tied to 0 and the alarm latch is not built.
  - The port remains present, so top-level wiring is unchanged.

## Structure
- Shared package timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE)
  - SEC_MAX = 59
  - SEC_W = 6
- One sub-module is natural: sec_down_counter.
  - 0..59 modulo down-counter with load, enable, and a registered borrow output asserted on the 0 → 59 wrap.
  - It is the mirror of the seconds up-counter.
- The minute field and the FSM live in countdown_timer.

## Test plan
- Reset while running at 05:30 → next edge: 00:00, IDLE, running = 0, expired = 0, alarm = 0.
- Load 01:00, start, 1 tick → 00:59 (borrow), minute = 0. 59 more ticks → 00:00, expired pulse of 1 cycle, state DONE; further ticks keep 00:00.
- Load 00:03, start, tick, pause, 3 ticks, start, tick → 00:01 with the count frozen during pause. Next tick → expired.
- Load with load_sec = 63, load_min = 120 → second = 59, minute = 99. Load 00:00 then start → expired one cycle later, no decrement.
- Simultaneous load = 1, tick = 1, start = 1 in RUN at 02:10 → preset loaded, IDLE, no decrement, running = 0.
- With COUNTDOWN_ALARM_EN: alarm rises with expired, stays high through 10 idle cycles and a start, and clears on load. Without the macro, alarm stays 0 throughout.
